// File: rtl/if_pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the IF-stage hazard controller.
// master : datapath side, drives hazard inputs, consumes control outputs
// slave  : controller side (if_pipeline_ctrl)
// Inputs : rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, rd_IDEX, MemRead_IDEX,
//          branch_taken_EX, branch_target_EX, dmem_busy
// Outputs: PCWrite, Write_IFID, flush_IF, flush_IDEX, hold_EX, PCSrc_IF, PCTarget_IF,
//          mem_timeout, stall_cnt, flush_cnt, freeze_cnt
interface if_pipeline_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       rs1_ID;
  logic [4:0]       rs2_ID;
  logic             uses_rs1_ID;
  logic             uses_rs2_ID;
  logic [4:0]       rd_IDEX;
  logic             MemRead_IDEX;
  logic             branch_taken_EX;
  logic [31:0]      branch_target_EX;  // signed byte address
  logic             dmem_busy;

  logic             PCWrite;
  logic             Write_IFID;
  logic             flush_IF;
  logic             flush_IDEX;
  logic             hold_EX;
  logic             PCSrc_IF;
  logic [31:0]      PCTarget_IF;       // signed byte address
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] freeze_cnt;

  modport master (
    output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, rd_IDEX, MemRead_IDEX,
           branch_taken_EX, branch_target_EX, dmem_busy,
    input  PCWrite, Write_IFID, flush_IF, flush_IDEX, hold_EX, PCSrc_IF, PCTarget_IF,
           mem_timeout, stall_cnt, flush_cnt, freeze_cnt
  );

  modport slave (
    input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, rd_IDEX, MemRead_IDEX,
           branch_taken_EX, branch_target_EX, dmem_busy,
    output PCWrite, Write_IFID, flush_IF, flush_IDEX, hold_EX, PCSrc_IF, PCTarget_IF,
           mem_timeout, stall_cnt, flush_cnt, freeze_cnt
  );
endinterface

// File: rtl/if_pipeline_ctrl.sv
// IF-stage / IF-ID hazard and sequencing controller.
// Boot flush for synchronous IMEM, load-use bubbles, EX branch redirects, DMEM freezes with a
// timeout trap, and saturating performance counters.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - if_pipeline_ctrl_if.slave: hazard inputs, fetch/pipeline controls, counters
// Control outputs are combinational from the state and the live hazard inputs.
module if_pipeline_ctrl #(
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  if_pipeline_ctrl_if.slave  bus
);

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam int unsigned WW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_WAIT_MAX);

  typedef enum logic [1:0] {StBoot, StRun, StMemWait, StError} state_e;

  state_e           state_q;
  logic [BW-1:0]    boot_cnt_q;
  logic [WW-1:0]    wait_cnt_q;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic load_use, boot, freeze, redirect, stall;

  assign load_use = bus.MemRead_IDEX && (bus.rd_IDEX != 5'd0) &&
                    ((bus.uses_rs1_ID && (bus.rs1_ID == bus.rd_IDEX)) ||
                     (bus.uses_rs2_ID && (bus.rs2_ID == bus.rd_IDEX)));

  // Action decode; priority busy > branch > load-use. MEM_WAIT with busy low behaves like RUN,
  // so a branch parked in EX during the freeze is redirected on the release cycle.
  always_comb begin
    boot     = 1'b0;
    freeze   = 1'b0;
    redirect = 1'b0;
    stall    = 1'b0;
    if (rst) begin
      boot = 1'b1;
    end else begin
      unique case (state_q)
        StBoot: boot = 1'b1;
        StRun, StMemWait: begin
          if (bus.dmem_busy)            freeze   = 1'b1;
          else if (bus.branch_taken_EX) redirect = 1'b1;
          else if (load_use)            stall    = 1'b1;
        end
        StError: freeze = 1'b1;
        default: boot = 1'b1;
      endcase
    end
  end

  assign bus.PCWrite     = ~(boot | freeze | stall);
  assign bus.Write_IFID  = ~(boot | freeze | stall);
  assign bus.flush_IF    = boot | redirect;
  assign bus.flush_IDEX  = boot | redirect | stall;
  assign bus.hold_EX     = freeze;
  assign bus.PCSrc_IF    = redirect;
  assign bus.PCTarget_IF = redirect ? bus.branch_target_EX : 32'd0;
  assign bus.mem_timeout = mem_timeout_q;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;
  assign bus.freeze_cnt  = freeze_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      boot_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      freeze_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        StBoot: begin
          if (boot_cnt_q == BOOT_LAST) state_q    <= StRun;
          else                         boot_cnt_q <= boot_cnt_q + 1'b1;
        end
        StRun: begin
          if (bus.dmem_busy) begin
            wait_cnt_q <= WW'(1);
            state_q    <= StMemWait;
          end
        end
        StMemWait: begin
          if (bus.dmem_busy) begin
            // Busy for the (MEM_WAIT_MAX+1)-th consecutive cycle: trap.
            if (wait_cnt_q == WAIT_MAX) begin
              state_q       <= StError;
              mem_timeout_q <= 1'b1;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end else begin
            state_q <= StRun;
          end
        end
        StError: state_q <= StError;
        default: state_q <= StBoot;
      endcase

      if (stall && (stall_cnt_q != '1))     stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != '1))  flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (freeze && (freeze_cnt_q != '1))   freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_pipeline_ctrl.sv
// Bench for if_pipeline_ctrl. dut_a (MEM_WAIT_MAX=4, CNT_W=16) is fully checked; dut_b
// (MEM_WAIT_MAX=4, CNT_W=2) sees the same stimulus and has its stall counter checked for saturation.
module tb_if_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_pipeline_ctrl_if #(.CNT_W(16)) bus_a ();
  if_pipeline_ctrl_if #(.CNT_W(2))  bus_b ();

  if_pipeline_ctrl #(.BOOT_CYCLES(2), .MEM_WAIT_MAX(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  if_pipeline_ctrl #(.BOOT_CYCLES(2), .MEM_WAIT_MAX(4), .CNT_W(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  assign bus_b.rs1_ID           = bus_a.rs1_ID;
  assign bus_b.rs2_ID           = bus_a.rs2_ID;
  assign bus_b.uses_rs1_ID      = bus_a.uses_rs1_ID;
  assign bus_b.uses_rs2_ID      = bus_a.uses_rs2_ID;
  assign bus_b.rd_IDEX          = bus_a.rd_IDEX;
  assign bus_b.MemRead_IDEX     = bus_a.MemRead_IDEX;
  assign bus_b.branch_taken_EX  = bus_a.branch_taken_EX;
  assign bus_b.branch_target_EX = bus_a.branch_target_EX;
  assign bus_b.dmem_busy        = bus_a.dmem_busy;

  // Control pattern {PCWrite, Write_IFID, flush_IF, flush_IDEX, hold_EX, PCSrc_IF}
  localparam logic [5:0] C_BOOT = 6'b001100;
  localparam logic [5:0] C_RUN  = 6'b110000;
  localparam logic [5:0] C_FRZ  = 6'b000010;
  localparam logic [5:0] C_BR   = 6'b111101;
  localparam logic [5:0] C_LU   = 6'b000100;

  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic [31:0] tgt;
    logic        mto;
    int          s, f, z, s2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", nm, fld, act, want);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; pop one expectation per cycle presented.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.nm, "ctl", {26'd0, bus_a.PCWrite, bus_a.Write_IFID, bus_a.flush_IF,
                        bus_a.flush_IDEX, bus_a.hold_EX, bus_a.PCSrc_IF}, {26'd0, e.ctl});
      chk(e.nm, "PCTarget_IF", bus_a.PCTarget_IF, e.tgt);
      chk(e.nm, "mem_timeout", {31'd0, bus_a.mem_timeout}, {31'd0, e.mto});
      chk(e.nm, "stall_cnt", {16'd0, bus_a.stall_cnt}, e.s);
      chk(e.nm, "flush_cnt", {16'd0, bus_a.flush_cnt}, e.f);
      chk(e.nm, "freeze_cnt", {16'd0, bus_a.freeze_cnt}, e.z);
      chk(e.nm, "stall_cnt_w2", {30'd0, bus_b.stall_cnt}, e.s2);
    end
  end

  task automatic drv(input logic r, input logic busy, input logic br, input logic [31:0] tgt,
                     input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic u1, input logic u2);
    rst                    = r;
    bus_a.dmem_busy        = busy;
    bus_a.branch_taken_EX  = br;
    bus_a.branch_target_EX = tgt;
    bus_a.MemRead_IDEX     = mr;
    bus_a.rd_IDEX          = rd;
    bus_a.rs1_ID           = rs1;
    bus_a.rs2_ID           = rs2;
    bus_a.uses_rs1_ID      = u1;
    bus_a.uses_rs2_ID      = u2;
  endtask

  task automatic idle(input logic r);
    drv(r, 1'b0, 1'b0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  // Push the expectation for the current cycle, then advance one cycle.
  task automatic expect_cyc(input string nm, input logic [5:0] ctl, input logic [31:0] tgt,
                            input logic mto, input int s, input int f, input int z,
                            input int s2);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.tgt = tgt; e.mto = mto;
    e.s = s; e.f = f; e.z = z; e.s2 = s2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle(1'b1);
    repeat (2) @(posedge clk);
    #1;
    // Reset and boot
    expect_cyc("rst", C_BOOT, 0, 0, 0, 0, 0, 0);
    idle(1'b0);
    expect_cyc("boot1", C_BOOT, 0, 0, 0, 0, 0, 0);
    expect_cyc("boot2", C_BOOT, 0, 0, 0, 0, 0, 0);
    expect_cyc("run", C_RUN, 0, 0, 0, 0, 0, 0);
    // Load-use
    drv(0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    expect_cyc("lu_hit", C_LU, 0, 0, 0, 0, 0, 0);
    idle(1'b0);
    expect_cyc("lu_after", C_RUN, 0, 0, 1, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 1);
    expect_cyc("lu_rd0", C_RUN, 0, 0, 1, 0, 0, 1);
    drv(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0);
    expect_cyc("lu_nouse", C_RUN, 0, 0, 1, 0, 0, 1);
    // Branch together with a load-use
    drv(0, 0, 1, 32'h40, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    expect_cyc("br_lu", C_BR, 32'h40, 0, 1, 0, 0, 1);
    idle(1'b0);
    expect_cyc("br_after", C_RUN, 0, 0, 1, 1, 0, 1);
    // Freeze 4 cycles with a branch parked in EX, redirect on release
    drv(0, 1, 1, 32'h80, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    expect_cyc("frz1", C_FRZ, 0, 0, 1, 1, 0, 1);
    expect_cyc("frz2", C_FRZ, 0, 0, 1, 1, 1, 1);
    expect_cyc("frz3", C_FRZ, 0, 0, 1, 1, 2, 1);
    expect_cyc("frz4", C_FRZ, 0, 0, 1, 1, 3, 1);
    drv(0, 0, 1, 32'h80, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    expect_cyc("rel_br", C_BR, 32'h80, 0, 1, 1, 4, 1);
    idle(1'b0);
    expect_cyc("rel_br_after", C_RUN, 0, 0, 1, 2, 4, 1);
    // Busy beats load-use, then load-use on release
    drv(0, 1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    expect_cyc("frz_lu", C_FRZ, 0, 0, 1, 2, 4, 1);
    drv(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    expect_cyc("rel_lu", C_LU, 0, 0, 1, 2, 5, 1);
    idle(1'b0);
    expect_cyc("rel_lu_after", C_RUN, 0, 0, 2, 2, 5, 2);
    // Timeout: 5 consecutive busy cycles
    drv(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    expect_cyc("to1", C_FRZ, 0, 0, 2, 2, 5, 2);
    expect_cyc("to2", C_FRZ, 0, 0, 2, 2, 6, 2);
    expect_cyc("to3", C_FRZ, 0, 0, 2, 2, 7, 2);
    expect_cyc("to4", C_FRZ, 0, 0, 2, 2, 8, 2);
    expect_cyc("to5", C_FRZ, 0, 0, 2, 2, 9, 2);
    idle(1'b0);
    expect_cyc("err1", C_FRZ, 0, 1, 2, 2, 10, 2);
    drv(0, 0, 1, 32'h40, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    expect_cyc("err2", C_FRZ, 0, 1, 2, 2, 11, 2);
    // Reset out of ERROR
    idle(1'b1);
    @(posedge clk);
    #1;
    expect_cyc("rst2", C_BOOT, 0, 0, 0, 0, 0, 0);
    idle(1'b0);
    expect_cyc("boot1b", C_BOOT, 0, 0, 0, 0, 0, 0);
    expect_cyc("boot2b", C_BOOT, 0, 0, 0, 0, 0, 0);
    expect_cyc("runb", C_RUN, 0, 0, 0, 0, 0, 0);
    // Five load-use events; the 2-bit counter must stop at 3
    for (int k = 1; k <= 5; k++) begin
      drv(0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
      expect_cyc("sat_lu", C_LU, 0, 0, k - 1, 0, 0, (k - 1 > 3) ? 3 : k - 1);
      idle(1'b0);
      expect_cyc("sat_idle", C_RUN, 0, 0, k, 0, 0, (k > 3) ? 3 : k);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
